// File: rtl/sdram_test_pkg.sv
// Shared types and command-word layout for the SDRAM pattern tester.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_SEED  = 2'd0,
    MODE_ADDR  = 2'd1,
    MODE_NADDR = 2'd2,
    MODE_XOR   = 2'd3
  } mode_t;

  // Command word is {we, addr, data}, data in the low bits.
  function automatic int cmd_data_lsb();
    return 0;
  endfunction

  function automatic int cmd_addr_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int cmd_we_bit(input int addr_width, input int data_width);
    return addr_width + data_width;
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational pattern generator: expected data word from mode, seed,
// pass parity and the low address bits.
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  mode_t                 mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  invert,
  input  logic [DATA_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] base;

  always_comb begin
    base = seed;
    case (mode)
      MODE_SEED:  base = seed;
      MODE_ADDR:  base = addr;
      MODE_NADDR: base = ~addr;
      MODE_XOR:   base = addr ^ seed;
      default:    base = seed;
    endcase
    data = invert ? ~base : base;
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// Pattern tester: writes a seeded pattern across an SDRAM window, reads it
// back through the controller FIFOs and counts mismatches.
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int ADDR_WIDTH      = 24,
  parameter int DATA_WIDTH      = 16,
  parameter int BASE_ADDR       = 0,
  parameter int NUM_WORDS       = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             reset_i,
  input  logic                             start_i,
  input  logic                             abort_i,
  input  logic [1:0]                       mode_i,
  input  logic [DATA_WIDTH-1:0]            seed_i,
  input  logic                             loop_i,
  output logic [ADDR_WIDTH+DATA_WIDTH:0]   writer_d_o,
  output logic                             writer_enq_o,
  input  logic                             writer_full_i,
  input  logic [DATA_WIDTH-1:0]            reader_q_i,
  output logic                             reader_deq_o,
  input  logic                             reader_empty_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             error_o,
  output logic [15:0]                      err_count_o,
  output logic [ADDR_WIDTH-1:0]            first_err_addr_o,
  output logic [15:0]                      pass_count_o
);

  localparam int IDX_W    = $clog2(NUM_WORDS + 1);
  localparam int CMD_W    = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int WE_BIT   = cmd_we_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int ADDR_LSB = cmd_addr_lsb(DATA_WIDTH);
  localparam int DATA_LSB = cmd_data_lsb();
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0]      END_IDX  = IDX_W'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [3:0]            MAX_OUT  = 4'(MAX_OUTSTANDING);

  state_t                state, state_nx;
  mode_t                 mode_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [IDX_W-1:0]      wr_idx, rd_idx, chk_idx;
  logic [3:0]            outstanding;
  logic                  wr_en, rd_en, deq_en, pass_done;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, chk_addr;
  logic [DATA_WIDTH-1:0] wr_data, chk_data;
  logic [CMD_W-1:0]      cmd;

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign wr_addr  = BASE + ADDR_WIDTH'(wr_idx);
  assign rd_addr  = BASE + ADDR_WIDTH'(rd_idx);
  assign chk_addr = BASE + ADDR_WIDTH'(chk_idx);

  sdram_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_issue_gen (
    .mode   (mode_q),
    .seed   (seed_q),
    .invert (pass_count_o[0]),
    .addr   (wr_addr[DATA_WIDTH-1:0]),
    .data   (wr_data)
  );

  sdram_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_check_gen (
    .mode   (mode_q),
    .seed   (seed_q),
    .invert (pass_count_o[0]),
    .addr   (chk_addr[DATA_WIDTH-1:0]),
    .data   (chk_data)
  );

  // A pass completing on the same cycle as abort still counts, but ends the run.
  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    deq_en    = 1'b0;
    pass_done = 1'b0;
    case (state)
      IDLE: if (start_i) state_nx = WRITE;
      WRITE: begin
        if (abort_i) begin
          state_nx = DRAIN;
        end else if (!writer_full_i) begin
          wr_en = 1'b1;
          if (wr_idx == LAST_IDX) state_nx = READ;
        end
      end
      READ: begin
        deq_en    = !reader_empty_i && (outstanding != 4'd0);
        rd_en     = !abort_i && !writer_full_i && (rd_idx != END_IDX) &&
                    (outstanding < MAX_OUT);
        pass_done = deq_en && (chk_idx == LAST_IDX);
        if (pass_done) state_nx = (loop_i && !abort_i) ? WRITE : DONE;
        else if (abort_i) state_nx = DRAIN;
      end
      DRAIN: begin
        deq_en = !reader_empty_i && (outstanding != 4'd0);
        if (outstanding == 4'd0) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd = '0;
    if (wr_en) begin
      cmd[WE_BIT]                      = 1'b1;
      cmd[ADDR_LSB +: ADDR_WIDTH]      = wr_addr;
      cmd[DATA_LSB +: DATA_WIDTH]      = wr_data;
    end else if (rd_en) begin
      cmd[ADDR_LSB +: ADDR_WIDTH]      = rd_addr;
    end
  end

  assign writer_d_o   = cmd;
  assign writer_enq_o = wr_en | rd_en;
  assign reader_deq_o = deq_en;
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state            <= IDLE;
      mode_q           <= MODE_SEED;
      seed_q           <= '0;
      wr_idx           <= '0;
      rd_idx           <= '0;
      chk_idx          <= '0;
      outstanding      <= '0;
      error_o          <= 1'b0;
      err_count_o      <= '0;
      first_err_addr_o <= '0;
      pass_count_o     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start_i) begin
        mode_q           <= mode_t'(mode_i);
        seed_q           <= seed_i;
        wr_idx           <= '0;
        rd_idx           <= '0;
        chk_idx          <= '0;
        outstanding      <= '0;
        error_o          <= 1'b0;
        err_count_o      <= '0;
        first_err_addr_o <= '0;
        pass_count_o     <= '0;
      end
      if (wr_en) wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
      if (rd_en) rd_idx <= rd_idx + IDX_W'(1);
      if (deq_en) begin
        chk_idx <= chk_idx + IDX_W'(1);
        if (reader_q_i != chk_data) begin
          error_o <= 1'b1;
          if (!error_o) first_err_addr_o <= chk_addr;
          if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
        end
      end
      if (rd_en && !deq_en) outstanding <= outstanding + 4'd1;
      else if (deq_en && !rd_en) outstanding <= outstanding - 4'd1;
      if (pass_done) begin
        pass_count_o <= pass_count_o + 16'd1;
        wr_idx       <= '0;
        rd_idx       <= '0;
        chk_idx      <= '0;
      end
    end
  end

endmodule

// File: doc/sdram_pattern_tester.md
SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH = 24: command address width.
- DATA_WIDTH = 16: data word width.
- BASE_ADDR = 0: first tested address.
- NUM_WORDS = 1024: words per pass, at least 1.
- MAX_OUTSTANDING = 4: maximum in-flight reads, 1..15.
REQ-002 Ports SHALL be:
- clk  in  1  single clock for all logic.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  starts a test run when idle.
- abort_i  in  1  stops the run after in-flight reads drain.
- mode_i  in  2  pattern select, sampled at start.
- seed_i  in  DATA_WIDTH  pattern seed, sampled at start.
- loop_i  in  1  repeat passes until abort.
- writer_d_o  out  1+ADDR_WIDTH+DATA_WIDTH  command {we, addr, data}.
- writer_enq_o  out  1  command enqueue strobe.
- writer_full_i  in  1  command FIFO full.
- reader_q_i  in  DATA_WIDTH  read data; valid while reader_empty_i=0 (first-word-fall-through).
- reader_deq_i is not a port; reader_deq_o  out  1  pops reader_q_i.
- reader_empty_i  in  1  read FIFO empty.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at run end.
- error_o  out  1  sticky mismatch flag.
- err_count_o  out  16  saturating mismatch count.
- first_err_addr_o  out  ADDR_WIDTH  address of first mismatch.
- pass_count_o  out  16  completed passes, wraps.

Function
REQ-003 FSM SHALL have states IDLE, WRITE, READ, DRAIN, DONE; start_i in IDLE SHALL latch mode_i/seed_i, clear error_o, err_count_o, first_err_addr_o, pass_count_o, and enter WRITE next cycle.
REQ-004 Expected data SHALL be a pure function of address a and latched seed s: mode 0 = s, mode 1 = a[DW-1:0], mode 2 = ~a[DW-1:0], mode 3 = a[DW-1:0] ^ s; on odd pass_count_o the pattern SHALL be bitwise inverted.
REQ-005 WRITE SHALL issue one write command {1, BASE_ADDR+i, pattern} per cycle while writer_full_i=0, for i = 0..NUM_WORDS-1, then go to READ; no enqueue SHALL occur while writer_full_i=1.
REQ-006 READ SHALL issue read commands {0, addr, 0} in address order when writer_full_i=0 and outstanding < MAX_OUTSTANDING.
REQ-007 Concurrently in READ, when reader_empty_i=0 and outstanding > 0, the block SHALL assert reader_deq_o for one cycle and compare reader_q_i against the expected value for the oldest outstanding address.
REQ-008 Outstanding count SHALL be +1 on read issue, -1 on dequeue, and unchanged when both occur in the same cycle; it SHALL never exceed MAX_OUTSTANDING.
REQ-009 On mismatch: error_o<=1; err_count_o += 1, saturating at 16'hFFFF; first_err_addr_o SHALL be set only on the first mismatch of the run.
REQ-010 When all NUM_WORDS responses are checked, pass_count_o SHALL increment; if loop_i=1 and no abort is pending, the FSM SHALL go to WRITE, otherwise to DONE.
REQ-011 DONE SHALL pulse done_o for one cycle and return to IDLE; busy_o=1 in every state except IDLE.
REQ-012 abort_i in WRITE or READ SHALL stop new commands and enter DRAIN; DRAIN SHALL dequeue and check remaining outstanding responses, then enter DONE without incrementing pass_count_o.
REQ-013 start_i outside IDLE and abort_i in IDLE SHALL be ignored.
REQ-014 Address arithmetic SHALL be modulo 2^ADDR_WIDTH (BASE_ADDR+NUM_WORDS wraps to 0).
REQ-015 writer_enq_o and reader_deq_o SHALL each be high for exactly one cycle per transfer.

Reset
REQ-016 reset_i SHALL force, at any time including mid-run: state IDLE, all outputs 0, outstanding count 0.
REQ-017 In-flight FIFO contents are not tracked across reset; the integrator SHALL reset the controller FIFOs with the same reset_i.

Structure
REQ-018 A shared package sdram_test_pkg SHALL hold the state enum, the mode encoding, and the command-field offsets (WE bit, address, data).
REQ-019 The pattern function SHALL be a sub-module sdram_pattern_gen (combinational: mode, seed, invert, addr -> data), instantiated twice: once for the write/issue path and once for the check path.

Verification
REQ-020 The bench SHALL use a controller model with a FIFO and random full/empty stalls, and SHALL cover:
- mode 1, NUM_WORDS=8, BASE_ADDR=0x10 -> writes 0x0010..0x0017, reads match, err_count_o=0, pass_count_o=1, done_o pulses once.
- Model corrupts read data at address 0x13 to 0xDEAD -> error_o=1, err_count_o=1, first_err_addr_o=0x13.
- writer_full_i held high 20 cycles mid-WRITE -> no enqueue during the stall, all commands issued in order afterward.
- Read latency 30 cycles, MAX_OUTSTANDING=4 -> outstanding never exceeds 4, all 8 words checked.
- loop_i=1, mode 0, seed 0xBEEF, abort after pass 2 -> pass 1 data 0x4110, pass_count_o=2, remaining reads drained, done_o pulses.
- reset_i asserted mid-READ -> all outputs 0 next cycle, FSM in IDLE, new start_i runs cleanly.
